// File: rtl/mbf_interpolate.sv
// mbf_interpolate
//   Multichannel TDM interpolator (upsampler) for the DUC path. One frame is
//   one sample per channel. Frames are collected into a double-buffered
//   register bank. Each frame is then replayed as L phases x N channels,
//   either zero-stuffed (only phase 0 carries data) or sample-held.
//
// Ports
//   CLK, nRST        clock, asynchronous active-low reset
//   isConfig         configuration request; Data_Config_In is latched one
//                    cycle later
//   isConfigDone     one-cycle pulse once the new configuration is active
//   Data_Config_In   [7:0] interpolation factor L (0 is treated as 1),
//                    [8] mode (0 zero-stuff, 1 hold)
//   Data_In*         input sample stream (valid/ready, channel index)
//   Data_Out*        output sample stream (valid/ready, channel index,
//                    Last on phase L-1 / channel N-1)
//   Sync_Err         one-cycle pulse after an input with an unexpected
//                    channel index has been accepted
//
// state | meaning
// RUN   | normal operation, both sides may move
// LOAD  | latch L/mode, flush banks, pointers and output register
// DONE  | isConfigDone pulse, both sides stalled
module mbf_interpolate #(
  parameter int DATA_WIDTH            = 24,
  parameter int MBF_MAX_CHANNELS      = 2,
  parameter int MBF_IF_DEFAULT        = 2,
  parameter int MBF_CONFIG_DATA_WIDTH = 16
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic                             isConfig,
  output logic                             isConfigDone,
  input  logic [MBF_CONFIG_DATA_WIDTH-1:0] Data_Config_In,
  input  logic [DATA_WIDTH-1:0]            Data_In,
  input  logic                             Data_In_Valid,
  input  logic [3:0]                       Data_In_ChIdx,
  output logic                             Data_In_Ready,
  output logic [DATA_WIDTH-1:0]            Data_Out,
  output logic                             Data_Out_Valid,
  output logic [3:0]                       Data_Out_ChIdx,
  output logic                             Data_Out_Last,
  input  logic                             Data_Out_Ready,
  output logic                             Sync_Err
);

  localparam int         CHW     = (MBF_MAX_CHANNELS > 1) ? $clog2(MBF_MAX_CHANNELS) : 1;
  localparam logic [3:0] LAST_CH = 4'(MBF_MAX_CHANNELS - 1);
  localparam logic [7:0] L_RESET = (MBF_IF_DEFAULT == 0) ? 8'd1 : 8'(MBF_IF_DEFAULT);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [0:1][0:MBF_MAX_CHANNELS-1];
  logic [1:0]            bank_full;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [3:0]            wr_ch;
  logic [3:0]            rd_ch;
  logic [7:0]            phase;
  logic [7:0]            l_cur;
  logic                  mode_hold;
  logic                  out_valid;

  logic                  in_accept;
  logic                  ch_match;
  logic                  wr_en;
  logic                  wr_done;
  logic                  out_load;
  logic                  rd_avail;
  logic                  rd_frame_end;
  logic                  rd_free;
  logic [7:0]            l_last;
  logic [7:0]            cfg_l;
  logic                  unused_cfg;

  // Only [8:0] of the configuration word carries meaning.
  assign unused_cfg = ^Data_Config_In;
  assign cfg_l      = Data_Config_In[7:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    isConfigDone   = 1'b0;
    Data_In_Ready  = 1'b0;
    Data_Out_Valid = 1'b0;
    case (state)
      ST_RUN: begin
        Data_In_Ready  = ~bank_full[wr_bank];
        Data_Out_Valid = out_valid;
        if (isConfig) state_nxt = ST_LOAD;
      end
      ST_LOAD: state_nxt = ST_DONE;
      ST_DONE: begin
        isConfigDone = 1'b1;
        state_nxt    = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      l_cur     <= L_RESET;
      mode_hold <= 1'b0;
    end else if (state == ST_LOAD) begin
      l_cur     <= (cfg_l == 8'd0) ? 8'd1 : cfg_l;
      mode_hold <= Data_Config_In[8];
    end
  end

  // ---------------------------------------------------------- write side
  assign in_accept = Data_In_Valid & Data_In_Ready;
  assign ch_match  = (Data_In_ChIdx == wr_ch);
  // A stray channel 0 restarts the frame, so it is still written (at index 0).
  assign wr_en     = in_accept & (ch_match | (Data_In_ChIdx == 4'd0));
  assign wr_done   = in_accept &
                     ((ch_match & (wr_ch == LAST_CH)) |
                      (~ch_match & (Data_In_ChIdx == 4'd0) & (LAST_CH == 4'd0)));

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_bank][Data_In_ChIdx[CHW-1:0]] <= Data_In;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ch    <= 4'd0;
      wr_bank  <= 1'b0;
      Sync_Err <= 1'b0;
    end else begin
      Sync_Err <= 1'b0;
      if (state == ST_LOAD) begin
        wr_ch   <= 4'd0;
        wr_bank <= 1'b0;
      end else if (in_accept) begin
        Sync_Err <= ~ch_match;
        if (wr_done) begin
          wr_ch   <= 4'd0;
          wr_bank <= ~wr_bank;
        end else if (ch_match) begin
          wr_ch <= wr_ch + 4'd1;
        end else if (Data_In_ChIdx == 4'd0) begin
          wr_ch <= 4'd1;
        end else begin
          wr_ch <= 4'd0;
        end
      end
    end
  end

  // ----------------------------------------------------------- read side
  assign l_last       = l_cur - 8'd1;
  assign out_load     = ~out_valid | Data_Out_Ready;
  assign rd_avail     = (state == ST_RUN) & bank_full[rd_bank];
  assign rd_frame_end = (phase == l_last) & (rd_ch == LAST_CH);
  assign rd_free      = out_load & rd_avail & rd_frame_end;

  // The write side only completes a non-full bank and the read side only
  // frees a full one, so the two updates never target the same bit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bank_full <= 2'b00;
    end else if (state == ST_LOAD) begin
      bank_full <= 2'b00;
    end else begin
      if (rd_free) bank_full[rd_bank] <= 1'b0;
      if (wr_done) bank_full[wr_bank] <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid      <= 1'b0;
      Data_Out       <= '0;
      Data_Out_ChIdx <= 4'd0;
      Data_Out_Last  <= 1'b0;
      rd_ch          <= 4'd0;
      phase          <= 8'd0;
      rd_bank        <= 1'b0;
    end else if (state == ST_LOAD) begin
      out_valid     <= 1'b0;
      Data_Out_Last <= 1'b0;
      rd_ch         <= 4'd0;
      phase         <= 8'd0;
      rd_bank       <= 1'b0;
    end else if (out_load) begin
      if (rd_avail) begin
        out_valid      <= 1'b1;
        Data_Out       <= ((phase == 8'd0) || mode_hold) ? mem[rd_bank][rd_ch[CHW-1:0]] : '0;
        Data_Out_ChIdx <= rd_ch;
        Data_Out_Last  <= rd_frame_end;
        if (rd_ch == LAST_CH) begin
          rd_ch <= 4'd0;
          if (phase == l_last) begin
            phase   <= 8'd0;
            rd_bank <= ~rd_bank;
          end else begin
            phase <= phase + 8'd1;
          end
        end else begin
          rd_ch <= rd_ch + 4'd1;
        end
      end else begin
        out_valid     <= 1'b0;
        Data_Out_Last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mbf_interpolate.sv
module tb_mbf_interpolate;

  localparam int NCH = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        isConfig;
  logic        isConfigDone;
  logic [15:0] Data_Config_In;
  logic [23:0] Data_In;
  logic        Data_In_Valid;
  logic [3:0]  Data_In_ChIdx;
  logic        Data_In_Ready;
  logic [23:0] Data_Out;
  logic        Data_Out_Valid;
  logic [3:0]  Data_Out_ChIdx;
  logic        Data_Out_Last;
  logic        Data_Out_Ready;
  logic        Sync_Err;

  mbf_interpolate #(
    .DATA_WIDTH(24), .MBF_MAX_CHANNELS(NCH), .MBF_IF_DEFAULT(2), .MBF_CONFIG_DATA_WIDTH(16)
  ) dut (
    .CLK(CLK), .nRST(nRST), .isConfig(isConfig), .isConfigDone(isConfigDone),
    .Data_Config_In(Data_Config_In), .Data_In(Data_In), .Data_In_Valid(Data_In_Valid),
    .Data_In_ChIdx(Data_In_ChIdx), .Data_In_Ready(Data_In_Ready), .Data_Out(Data_Out),
    .Data_Out_Valid(Data_Out_Valid), .Data_Out_ChIdx(Data_Out_ChIdx),
    .Data_Out_Last(Data_Out_Last), .Data_Out_Ready(Data_Out_Ready), .Sync_Err(Sync_Err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  typedef struct {
    logic [23:0] d;
    logic [3:0]  ch;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] part[NCH];
  int          wp       = 0;
  int          cur_l    = 2;
  bit          cur_mode = 1'b0;
  int          busy     = 0;   // 2: LOAD cycle next observed, 1: DONE cycle next
  bit          sync_due = 1'b0;
  int          acc_cnt  = 0;

  task automatic push_frame();
    for (int ph = 0; ph < cur_l; ph++) begin
      for (int c = 0; c < NCH; c++) begin
        exp_t e;
        e.d    = (ph == 0 || cur_mode) ? part[c] : 24'h0;
        e.ch   = 4'(c);
        e.last = (ph == cur_l - 1) && (c == NCH - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic model_accept(input logic [3:0] ch, input logic [23:0] d);
    acc_cnt++;
    if (int'(ch) == wp) begin
      part[wp] = d;
      if (wp == NCH - 1) begin
        push_frame();
        wp = 0;
      end else begin
        wp++;
      end
    end else if (ch == 4'd0) begin
      sync_due = 1'b1;
      part[0]  = d;
      if (NCH == 1) begin
        push_frame();
        wp = 0;
      end else begin
        wp = 1;
      end
    end else begin
      sync_due = 1'b1;
      wp       = 0;
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (nRST) begin
      chk("cfg_done", 32'(isConfigDone), 32'(busy == 1));
      chk("sync_err", 32'(Sync_Err), 32'(sync_due));
      if (busy != 0) begin
        chk("cfg_in_ready", 32'(Data_In_Ready), 32'd0);
        chk("cfg_out_valid", 32'(Data_Out_Valid), 32'd0);
      end
      if (Data_Out_Valid && Data_Out_Ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(Data_Out), 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(Data_Out), 32'(e.d));
          chk("out_ch", 32'(Data_Out_ChIdx), 32'(e.ch));
          chk("out_last", 32'(Data_Out_Last), 32'(e.last));
        end
      end
      sync_due = 1'b0;
      if (Data_In_Valid && Data_In_Ready) model_accept(Data_In_ChIdx, Data_In);
      if (busy == 2) begin
        cur_l    = (Data_Config_In[7:0] == 8'd0) ? 1 : int'(Data_Config_In[7:0]);
        cur_mode = Data_Config_In[8];
        busy     = 1;
      end else if (busy == 1) begin
        busy = 0;
      end else if (isConfig) begin
        exp_q.delete();
        wp   = 0;
        busy = 2;
      end
    end
  end

  // -------------------------------------------------------- stimulus
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [3:0] ch, input logic [23:0] d);
    int n = 0;
    Data_In_Valid = 1'b1;
    Data_In_ChIdx = ch;
    Data_In       = d;
    @(negedge CLK);
    while (!Data_In_Ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!Data_In_Ready) chk("send_timeout", 32'(n), 32'd0);
    @(posedge CLK);
    #1;
    Data_In_Valid = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] word);
    isConfig       = 1'b1;
    Data_Config_In = word;
    step();
    isConfig = 1'b0;
    chk("load_out_valid", 32'(Data_Out_Valid), 32'd0);
    chk("load_in_ready", 32'(Data_In_Ready), 32'd0);
    chk("load_done", 32'(isConfigDone), 32'd0);
    step();
    chk("done_pulse", 32'(isConfigDone), 32'd1);
    step();
    chk("done_end", 32'(isConfigDone), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || Data_Out_Valid) && n < 300) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    nRST           = 1'b0;
    isConfig       = 1'b0;
    Data_Config_In = 16'h0;
    Data_In        = 24'h0;
    Data_In_Valid  = 1'b0;
    Data_In_ChIdx  = 4'd0;
    Data_Out_Ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(Data_Out_Valid), 32'd0);
    chk("rst_out_data", 32'(Data_Out), 32'd0);
    chk("rst_out_ch", 32'(Data_Out_ChIdx), 32'd0);
    chk("rst_out_last", 32'(Data_Out_Last), 32'd0);
    chk("rst_cfg_done", 32'(isConfigDone), 32'd0);
    chk("rst_sync_err", 32'(Sync_Err), 32'd0);
    chk("rst_in_ready", 32'(Data_In_Ready), 32'd1);
    #10;
    nRST = 1'b1;
    step();

    // default L=2 zero-stuff
    send(4'd0, 24'h000100);
    send(4'd1, 24'h000200);
    chk("lat_not_yet", 32'(Data_Out_Valid), 32'd0);
    step();
    chk("t1_v0", 32'(Data_Out_Valid), 32'd1);
    chk("t1_d0", 32'(Data_Out), 32'h000100);
    chk("t1_c0", 32'(Data_Out_ChIdx), 32'd0);
    chk("t1_l0", 32'(Data_Out_Last), 32'd0);
    step();
    chk("t1_d1", 32'(Data_Out), 32'h000200);
    chk("t1_c1", 32'(Data_Out_ChIdx), 32'd1);
    step();
    chk("t1_d2", 32'(Data_Out), 32'h0);
    chk("t1_l2", 32'(Data_Out_Last), 32'd0);
    step();
    chk("t1_d3", 32'(Data_Out), 32'h0);
    chk("t1_c3", 32'(Data_Out_ChIdx), 32'd1);
    chk("t1_l3", 32'(Data_Out_Last), 32'd1);
    step();
    chk("t1_end_valid", 32'(Data_Out_Valid), 32'd0);

    // L=3 hold, full-scale extremes
    cfg(16'h0103);
    send(4'd0, 24'h7FFFFF);
    send(4'd1, 24'h800000);
    step();
    for (int i = 0; i < 6; i++) begin
      chk("t2_valid", 32'(Data_Out_Valid), 32'd1);
      chk("t2_data", 32'(Data_Out), (i % 2 == 0) ? 32'h7FFFFF : 32'h800000);
      chk("t2_last", 32'(Data_Out_Last), 32'(i == 5));
      step();
    end
    drain();

    // back-pressure: two frames buffered, output frozen
    Data_Out_Ready = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) send(4'(i % 2), 24'h10 + 24'(i));
      end
      begin
        repeat (5) step();
        chk("stall_data_a", 32'(Data_Out), 32'h10);
        repeat (5) step();
        chk("stall_in_ready", 32'(Data_In_Ready), 32'd0);
        chk("stall_valid", 32'(Data_Out_Valid), 32'd1);
        chk("stall_data_b", 32'(Data_Out), 32'h10);
        chk("stall_ch", 32'(Data_Out_ChIdx), 32'd0);
        chk("stall_accepts", 32'(acc_cnt - acc0), 32'd4);
        Data_Out_Ready = 1'b1;
      end
    join
    drain();

    // channel-index resync: 0,0,1
    send(4'd0, 24'h000AAA);
    chk("sync_quiet", 32'(Sync_Err), 32'd0);
    send(4'd0, 24'h000BBB);
    chk("sync_pulse", 32'(Sync_Err), 32'd1);
    send(4'd1, 24'h000CCC);
    chk("sync_clear", 32'(Sync_Err), 32'd0);
    step();
    chk("sync_frame_d0", 32'(Data_Out), 32'h000BBB);
    drain();

    // L=0 treated as 1: pass-through
    cfg(16'h0000);
    send(4'd0, 24'h000111);
    send(4'd1, 24'h000222);
    step();
    chk("l1_d0", 32'(Data_Out), 32'h000111);
    chk("l1_l0", 32'(Data_Out_Last), 32'd0);
    step();
    chk("l1_d1", 32'(Data_Out), 32'h000222);
    chk("l1_l1", 32'(Data_Out_Last), 32'd1);
    send(4'd0, 24'h000333);
    send(4'd1, 24'h000444);
    drain();

    // reconfigure mid-frame with a second frame already buffered
    cfg(16'h0003);
    send(4'd0, 24'h000055);
    send(4'd1, 24'h000066);
    send(4'd0, 24'h000099);
    send(4'd1, 24'h0000AA);
    chk("mid_valid_pre", 32'(Data_Out_Valid), 32'd1);
    cfg(16'h0102);
    send(4'd0, 24'h000077);
    send(4'd1, 24'h000088);
    step();
    chk("mid_d0", 32'(Data_Out), 32'h000077);
    step();
    chk("mid_d1", 32'(Data_Out), 32'h000088);
    step();
    chk("mid_d2", 32'(Data_Out), 32'h000077);
    step();
    chk("mid_d3", 32'(Data_Out), 32'h000088);
    chk("mid_l3", 32'(Data_Out_Last), 32'd1);
    drain();

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mbf_interpolate.md
Name: mbf_interpolate

Overview:
- Multichannel TDM interpolator (upsampler) for the DUC path. It is the transmit-side counterpart of the DDC decimator.
- Collects one frame of samples (one sample per channel, channel index 0..MBF_MAX_CHANNELS-1) into a double-buffered register bank.
- Replays each frame as MBF_IF phases x MBF_MAX_CHANNELS output samples, in either zero-stuff or sample-hold mode.
- Fully synchronous to CLK, with a ready/valid handshake on both sides. Uses the same isConfig / isConfigDone configuration handshake as the other MBF blocks.

Parameters:
- DATA_WIDTH, 24, sample width (two's complement).
- MBF_MAX_CHANNELS, 2, channels per frame; legal range 1..16.
- MBF_IF_DEFAULT, 2, interpolation factor L loaded at reset.
- MBF_CONFIG_DATA_WIDTH, 16, configuration word width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- isConfig  in  1  configuration request.
- isConfigDone  out  1  one-cycle pulse when the new configuration is active.
- Data_Config_In  in  MBF_CONFIG_DATA_WIDTH  [7:0] = L, [8] = mode (0 zero-stuff, 1 hold); other bits ignored.
- Data_In  in  DATA_WIDTH  input sample.
- Data_In_Valid  in  1  input sample valid.
- Data_In_ChIdx  in  4  input channel index.
- Data_In_Ready  out  1  block can accept an input sample.
- Data_Out  out  DATA_WIDTH  output sample.
- Data_Out_Valid  out  1  output sample valid.
- Data_Out_ChIdx  out  4  output channel index.
- Data_Out_Last  out  1  high on the final sample of a frame (phase L-1, channel N-1).
- Data_Out_Ready  in  1  downstream accepts the output.
- Sync_Err  out  1  one-cycle pulse when an input channel index mismatches.

Behaviour:
- Reset values: Data_Out=0, Data_Out_Valid=0, Data_Out_ChIdx=0, Data_Out_Last=0, isConfigDone=0, Sync_Err=0. Both banks empty, wr_ch=0, wr_bank=rd_bank=0, phase=0, rd_ch=0, L=MBF_IF_DEFAULT, mode=0, FSM in RUN.
- Data_In_Ready is combinational: 1 when FSM is RUN and bank_full[wr_bank]=0. It is therefore 1 during and immediately after reset.
- Config FSM: RUN -> LOAD when isConfig=1.
  - LOAD: latch L and mode. A latched L of 0 is stored as 1. Flush both banks, wr_ch, phase, rd_ch and Data_Out_Valid. Go to DONE.
  - DONE: isConfigDone=1 for this cycle only. Go to RUN.
  - isConfig high during LOAD or DONE is ignored.
  - In LOAD and DONE, Data_In_Ready=0 and Data_Out_Valid=0.
  - A configuration mid-frame aborts that frame; no partial output is produced.
- Input acceptance occurs when Data_In_Valid & Data_In_Ready.
  - If Data_In_ChIdx == wr_ch: write bank[wr_bank][wr_ch] and increment wr_ch.
  - If that write had wr_ch == N-1: set bank_full[wr_bank], toggle wr_bank, and clear wr_ch.
  - If Data_In_ChIdx != wr_ch and Data_In_ChIdx == 0: pulse Sync_Err, discard the partial frame, write the sample at index 0, and set wr_ch=1. If N=1, the frame completes instead.
  - If Data_In_ChIdx != wr_ch and Data_In_ChIdx != 0: pulse Sync_Err, drop the sample, and set wr_ch=0.
- Output register:
  - It loads when Data_Out_Valid=0 or Data_Out_Ready=1.
  - Loading requires bank_full[rd_bank]=1 and FSM in RUN.
  - Contents: Data_Out = bank[rd_bank][rd_ch] when phase==0 or mode==1, otherwise 0. Data_Out_ChIdx=rd_ch.
  - rd_ch advances 0..N-1 within a phase; phase advances 0..L-1.
  - When the loaded sample is (L-1, N-1): assert Data_Out_Last, clear bank_full[rd_bank], toggle rd_bank, reset phase and rd_ch.
  - If no full bank is available while the register loads, Data_Out_Valid goes to 0.
- Stall: Data_Out_Valid=1 with Data_Out_Ready=0 holds Data_Out, Data_Out_ChIdx and Data_Out_Last stable.
- Latency: the frame-completing input is accepted at edge t. bank_full is set at t. The first output (phase 0, channel 0) is valid after edge t+1.
- Throughput: with Data_Out_Ready=1, one output per clock. Input back-pressures once both banks are full.
- Simultaneous events: a bank being freed by the read side and the other bank completing on the write side in the same cycle are both honoured.
- No gain compensation is applied in zero-stuff mode. There is no arithmetic widening.
- L=1 passes samples through in frame order.

Test Plan:
- Reset, N=2, L=2, mode 0; input ch0=0x000100, ch1=0x000200 -> outputs (ch0,0x000100), (ch1,0x000200), (ch0,0), (ch1,0) on 4 consecutive clocks; Last on the 4th; first valid 1 clock after the ch1 accept edge.
- Config word 0x0103 (L=3, hold), then input 0x7FFFFF/0x800000 -> isConfigDone pulses 2 clocks after isConfig; 6 outputs alternate 0x7FFFFF and 0x800000, Last on the 6th.
- Data_Out_Ready held 0 for 10 clocks with continuous input -> exactly 2 frames buffered, Data_In_Ready=0, Data_Out frozen; release -> no loss or reorder.
- Input ChIdx sequence 0,0,1 -> Sync_Err pulses once at the second sample; the frame emitted uses the second ch0 value.
- Config 0x0000 -> L treated as 1, outputs equal inputs in order.
- isConfig asserted mid-output-frame -> Data_Out_Valid drops within 1 clock, remaining samples discarded, next frame emitted with the new L.
